amstrad_mem_arb: RTL and testbench
==================================

# amstrad_mem_arb

Byte-wide memory arbiter directly downstream of the Amstrad MMU. It takes the 23-bit mapped CPU address (`ram_A`) plus CPU read/write strobes, and video word-fetch requests from the CRTC/video path. It serialises both onto a single req/ack memory port and returns CPU read bytes and 16-bit video words. Video has priority; the CPU is stalled through `cpu_wait`.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: cycles to wait for `mem_ack` before aborting. Used only with the timeout feature.

Ports:
- `CLK`  in  1  single clock for all logic
- `reset`  in  1  synchronous, active-high
- `cpu_rd`  in  1  CPU read strobe; level input, rising edge starts an access
- `cpu_wr`  in  1  CPU write strobe; level input, rising edge starts an access
- `ram_A`  in  23  mapped CPU address from the MMU; sampled on the strobe edge
- `cpu_dout`  in  8  CPU write data; sampled on the strobe edge
- `cpu_din`  out  8  read data; holds the last read byte
- `cpu_wait`  out  1  high while a CPU access is pending or in flight
- `vid_req`  in  1  one-cycle video fetch request
- `vid_A`  in  16  video byte address, even-aligned, inside bank 0
- `vid_data`  out  16  fetched word: {byte at vid_A+1, byte at vid_A}
- `vid_valid`  out  1  one-cycle pulse when `vid_data` is updated
- `mem_addr`  out  23  memory address
- `mem_we`  out  1  write enable
- `mem_wdata`  out  8  write data
- `mem_req`  out  1  request; held until acknowledged
- `mem_ack`  in  1  one-cycle acknowledge; read data is valid with it
- `mem_rdata`  in  8  read data
- `mem_err`  out  1  sticky timeout flag (timeout build only; tied to 0 otherwise)

## Operation
- Edge detect: register `cpu_rd` and `cpu_wr`. A 0→1 transition sets `cpu_pend`, latches `ram_A` and `cpu_dout`, and records the access type.
  - If both strobes rise in the same cycle, the write is taken and the read is dropped.
  - A new CPU edge while `cpu_pend` is set is ignored.
- `vid_req` sets `vid_pend` and latches `vid_A`. A `vid_req` arriving while `vid_pend` is set or a video fetch is in flight is ignored.
- FSM states: IDLE, CPU_RD, CPU_WR, VID_LO, VID_HI.
  - IDLE: if `vid_pend`, go to VID_LO. Otherwise, if `cpu_pend`, go to CPU_RD or CPU_WR.
  - Each non-IDLE state drives `mem_req`=1 with a stable address, `mem_we` and `mem_wdata` until `mem_ack`.
  - VID_LO address is {7'b0, vid_A}. On ack: capture the low byte and go to VID_HI.
  - VID_HI address is {7'b0, vid_A | 1}. On ack: update `vid_data`, pulse `vid_valid`, clear `vid_pend`, and go to IDLE.
  - CPU_RD on ack: `cpu_din` ← `mem_rdata`, clear `cpu_pend`, go to IDLE.
  - CPU_WR on ack: clear `cpu_pend`, go to IDLE.
- A CPU access in flight is never pre-empted. Video waits at most one CPU access.
- `cpu_wait` = `cpu_pend` (combinational from the register).

## Timing
- Reset values:
  - FSM in IDLE
  - `mem_req`, `mem_we`, `cpu_wait`, `vid_valid`, `mem_err` = 0
  - `mem_addr` = 0, `mem_wdata` = 0, `cpu_din` = 8'hFF, `vid_data` = 0
  - pending flags cleared
- Strobe edge to `mem_req`: 2 cycles (1 for the edge register, 1 for IDLE→state). `mem_req` is registered.
- `mem_ack` in cycle N:
  - `mem_req` deasserts in N+1.
  - Result registers (`cpu_din`, `vid_data`) and `vid_valid` update in N+1.
  - `cpu_wait` falls in N+1.
  - The next request may assert in N+2.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset mid-access drops `mem_req` the next cycle. The memory controller must tolerate an abandoned request.

## Configuration
- `AMS_MEM_TIMEOUT_EN` defined: an 8-bit counter runs in every non-IDLE state. If `TIMEOUT_CYC` cycles pass without `mem_ack`:
  - The access is aborted.
  - A CPU read returns 8'hFF.
  - A video fetch returns 16'hFFFF with `vid_valid`.
  - `mem_err` is set and stays set until `reset`.
- Undefined: no counter; the FSM waits for `mem_ack` indefinitely; `mem_err` is tied to 0.

## Structure
- Shared package `amstrad_pkg`:
  - FSM state enum
  - address width constant (23)
  - `VID_BANK` constant (7'b0)
  - read-abort value 8'hFF
- Optional sub-module `amstrad_edge_det` for the strobe edge detection, instanced twice. Everything else stays flat.

## Test plan
- CPU read, `ram_A`=23'h01C123, `mem_ack` after 3 cycles with `mem_rdata`=8'h5A → one request to 23'h01C123 with `mem_we`=0; `cpu_din`=8'h5A; `cpu_wait` falls the cycle after ack.
- CPU write 8'hA5 to 23'h008000 → `mem_we`=1 and `mem_wdata`=8'hA5 stable until ack; exactly one request.
- `vid_req` with `vid_A`=16'hC000 in the same cycle as a `cpu_rd` edge → requests in order C000, C001, then the CPU address; `vid_data`={hi, lo}; `vid_valid` pulses once.
- `cpu_rd` and `cpu_wr` rise together → only a write is issued; a second `vid_req` during VID_HI is ignored, so only one `vid_valid`.
- Reset asserted while in CPU_RD with `mem_req` high → `mem_req`=0 next cycle; all outputs at reset values; a late `mem_ack` has no effect.
- With `AMS_MEM_TIMEOUT_EN`, never ack → abort after 255 cycles; `cpu_din`=8'hFF; `mem_err`=1 until reset.

Source files
------------

// File: rtl/amstrad_pkg.sv
// Shared definitions for the Amstrad memory arbiter: FSM states, address
// width, video bank and the value returned by an aborted CPU read.
package amstrad_pkg;

    localparam int unsigned ADDR_W   = 23;
    localparam logic [6:0]  VID_BANK = 7'b0;
    localparam logic [7:0]  RD_ABORT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_CPU_WR,
        ST_VID_LO,
        ST_VID_HI
    } arb_state_t;

endpackage

// File: rtl/amstrad_edge_det.sv
// Rising-edge detector for a level CPU strobe. The pulse is combinational
// from the live strobe and its one-cycle-delayed copy.
module amstrad_edge_det (
    input  logic CLK,
    input  logic reset,
    input  logic strobe,
    output logic rise
);

    logic strobe_q;

    // Delay the strobe by one cycle for edge comparison.
    always_ff @(posedge CLK) begin
        if (reset) strobe_q <= 1'b0;
        else       strobe_q <= strobe;
    end

    assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/amstrad_mem_arb.sv
// Byte-wide memory arbiter between the CPU (via the MMU) and video fetches.
// Video has priority; the CPU is stalled with cpu_wait.
// Optional build macro AMS_MEM_TIMEOUT_EN adds an ack timeout and mem_err.
module amstrad_mem_arb
    import amstrad_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] ram_A,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_wait,
    input  logic              vid_req,
    input  logic [15:0]       vid_A,
    output logic [15:0]       vid_data,
    output logic              vid_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              mem_err
);

    arb_state_t state, state_next;

    logic              rd_rise, wr_rise;
    logic              cpu_pend, cpu_is_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              vid_pend;
    logic [15:0]       vid_addr;
    logic [7:0]        vid_lo;
    logic              ack_ok, abort;
    logic              cpu_done, vid_done;
    logic              req_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        wdata_nxt;

    amstrad_edge_det u_rd_edge (.CLK(CLK), .reset(reset), .strobe(cpu_rd), .rise(rd_rise));
    amstrad_edge_det u_wr_edge (.CLK(CLK), .reset(reset), .strobe(cpu_wr), .rise(wr_rise));

    // An ack only counts against an outstanding request.
    assign ack_ok   = mem_ack & mem_req;
    assign cpu_wait = cpu_pend;
    assign cpu_done = ((state == ST_CPU_RD) || (state == ST_CPU_WR)) && (ack_ok || abort);
    assign vid_done = ((state == ST_VID_HI) && ack_ok) ||
                      (((state == ST_VID_LO) || (state == ST_VID_HI)) && abort);

`ifdef AMS_MEM_TIMEOUT_EN
    logic [7:0] tcnt;

    assign abort = (state != ST_IDLE) && !ack_ok && (tcnt == 8'(TIMEOUT_CYC - 1));

    // Per-state wait counter, restarted on every state change.
    always_ff @(posedge CLK) begin
        if (reset || (state == ST_IDLE) || (state_next != state)) tcnt <= '0;
        else                                                    tcnt <= tcnt + 8'd1;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (reset)      mem_err <= 1'b0;
        else if (abort) mem_err <= 1'b1;
    end
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;

    // TIMEOUT_CYC only shapes the timeout build; this keeps it referenced.
    if (TIMEOUT_CYC == 0) begin : g_timeout_unused
    end
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and the memory-port values for the state being entered.
    always_comb begin
        state_next = state;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;
        we_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vid_pend)      state_next = ST_VID_LO;
                else if (cpu_pend) state_next = cpu_is_wr ? ST_CPU_WR : ST_CPU_RD;
            end
            ST_CPU_RD, ST_CPU_WR, ST_VID_HI: begin
                if (ack_ok || abort) state_next = ST_IDLE;
            end
            ST_VID_LO: begin
                if (ack_ok)     state_next = ST_VID_HI;
                else if (abort) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        case (state_next)
            ST_CPU_RD: addr_nxt = cpu_addr;
            ST_CPU_WR: begin
                addr_nxt  = cpu_addr;
                wdata_nxt = cpu_wdata;
                we_nxt    = 1'b1;
            end
            ST_VID_LO: addr_nxt = {VID_BANK, vid_addr};
            ST_VID_HI: addr_nxt = {VID_BANK, vid_addr | 16'h0001};
            default:   ;
        endcase
        // Drop the request for one cycle after every ack, even VID_LO->VID_HI.
        req_nxt = (state_next != ST_IDLE) && !ack_ok;
    end

    // Registered memory port.
    always_ff @(posedge CLK) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

    // CPU request capture; write wins over a simultaneous read.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cpu_pend  <= 1'b0;
            cpu_is_wr <= 1'b0;
            cpu_addr  <= '0;
            cpu_wdata <= '0;
        end else if (cpu_pend) begin
            if (cpu_done) cpu_pend <= 1'b0;
        end else if (rd_rise || wr_rise) begin
            cpu_pend  <= 1'b1;
            cpu_is_wr <= wr_rise;
            cpu_addr  <= ram_A;
            cpu_wdata <= cpu_dout;
        end
    end

    // Video request capture; requests during a pending fetch are dropped.
    always_ff @(posedge CLK) begin
        if (reset) begin
            vid_pend <= 1'b0;
            vid_addr <= '0;
        end else if (vid_pend) begin
            if (vid_done) vid_pend <= 1'b0;
        end else if (vid_req) begin
            vid_pend <= 1'b1;
            vid_addr <= vid_A;
        end
    end

    // Result registers for CPU reads and video words.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cpu_din   <= RD_ABORT;
            vid_lo    <= '0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= 1'b0;
            if (state == ST_CPU_RD) begin
                if (ack_ok)     cpu_din <= mem_rdata;
                else if (abort) cpu_din <= RD_ABORT;
            end
            if ((state == ST_VID_LO) && ack_ok) vid_lo <= mem_rdata;
            if ((state == ST_VID_HI) && ack_ok) begin
                vid_data  <= {mem_rdata, vid_lo};
                vid_valid <= 1'b1;
            end else if (vid_done) begin
                vid_data  <= {RD_ABORT, RD_ABORT};
                vid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_amstrad_mem_arb.sv
// Self-checking bench for amstrad_mem_arb: a behavioural memory responder,
// a reference byte store and directed plus randomized scenarios.
module tb_amstrad_mem_arb;

    logic        CLK = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [22:0] ram_A;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_wait;
    logic        vid_req;
    logic [15:0] vid_A, vid_data;
    logic        vid_valid;
    logic [22:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_err;

    amstrad_mem_arb #(.TIMEOUT_CYC(255)) dut (
        .CLK(CLK), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .ram_A(ram_A),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_wait(cpu_wait), .vid_req(vid_req),
        .vid_A(vid_A), .vid_data(vid_data), .vid_valid(vid_valid), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [22:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } req_t;

    req_t        req_log[$];
    logic [7:0]  mem_arr[logic [22:0]];
    logic [7:0]  ref_arr[logic [22:0]];
    int unsigned n_checks = 0, n_pass = 0;
    bit          resp_en = 1'b0, in_req = 1'b0;
    int unsigned ack_delay = 0, wait_cnt = 0, stab_err = 0, vid_valid_cnt = 0;
    logic [15:0] last_vid = '0;
    req_t        cur;

    function automatic logic [7:0] init_byte(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_read(input logic [22:0] a);
        return ref_arr.exists(a) ? ref_arr[a] : init_byte(a);
    endfunction

    // Memory responder: logs each request, checks it stays stable, acks after ack_delay.
    always @(negedge CLK) begin
        if (vid_valid) begin
            vid_valid_cnt++;
            last_vid = vid_data;
        end
        if (resp_en) begin
            if (mem_ack) mem_ack = 1'b0;
            else if (!mem_req) in_req = 1'b0;
            else begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_cnt = 0;
                    cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata;
                    req_log.push_back(cur);
                end else if (mem_addr !== cur.addr || mem_we !== cur.we ||
                             (cur.we && mem_wdata !== cur.wdata)) begin
                    stab_err++;
                end
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_arr.exists(cur.addr) ? mem_arr[cur.addr] : init_byte(cur.addr);
                    if (cur.we) mem_arr[cur.addr] = cur.wdata;
                    in_req = 1'b0;
                end else begin
                    wait_cnt++;
                    mem_rdata = 8'($urandom);
                end
            end
        end
    end

    task automatic pulse_cpu(input bit rd, input bit wr, input logic [22:0] a, input logic [7:0] d);
        @(negedge CLK);
        ram_A = a; cpu_dout = d; cpu_rd = rd; cpu_wr = wr;
        @(negedge CLK);
        cpu_rd = 1'b0; cpu_wr = 1'b0; ram_A = 23'($urandom); cpu_dout = 8'($urandom);
    endtask

    task automatic wait_idle(input int unsigned exp_valid, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK); #1;
            if (!cpu_wait && !mem_req && vid_valid_cnt >= exp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (cpu_wait !== 1'b0) $display("FAIL rst_cpu_wait: got %b want 0", cpu_wait); else n_pass++;
        n_checks++; if (vid_valid !== 1'b0) $display("FAIL rst_vid_valid: got %b want 0", vid_valid); else n_pass++;
        n_checks++; if (mem_err !== 1'b0) $display("FAIL rst_mem_err: got %b want 0", mem_err); else n_pass++;
        n_checks++; if (mem_addr !== 23'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 8'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (cpu_din !== 8'hFF) $display("FAIL rst_cpu_din: got %h want ff", cpu_din); else n_pass++;
        n_checks++; if (vid_data !== 16'h0) $display("FAIL rst_vid_data: got %h want 0", vid_data); else n_pass++;
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_cpu_read;
        bit got = 1'b0, wait_ok = 1'b1;
        req_log.delete();
        resp_en = 1'b1; ack_delay = 3;
        mem_arr[23'h01C123] = 8'h5A; ref_arr[23'h01C123] = 8'h5A;
        @(negedge CLK);
        ram_A = 23'h01C123; cpu_rd = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (cpu_wait !== 1'b1) $display("FAIL rd_wait_set: got %b want 1", cpu_wait); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rd_req_cycle1: got %b want 0", mem_req); else n_pass++;
        @(negedge CLK);
        ram_A = 23'h0; cpu_rd = 1'b0;
        @(posedge CLK); #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rd_req_cycle2: got %b want 1", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 23'h01C123) $display("FAIL rd_addr: got %h want 01c123", mem_addr); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rd_we: got %b want 0", mem_we); else n_pass++;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (mem_ack) begin
                got = 1'b1;
                break;
            end
            if (!cpu_wait) wait_ok = 1'b0;
        end
        n_checks++; if (!got) $display("FAIL rd_ack_seen: got 0 want 1"); else n_pass++;
        n_checks++; if (!wait_ok) $display("FAIL rd_wait_held: got early drop want held"); else n_pass++;
        n_checks++; if (cpu_wait !== 1'b0) $display("FAIL rd_wait_fall: got %b want 0", cpu_wait); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rd_req_drop: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (cpu_din !== 8'h5A) $display("FAIL rd_data: got %h want 5a", cpu_din); else n_pass++;
        repeat (4) @(posedge CLK);
        #1;
        n_checks++; if (req_log.size() != 1) $display("FAIL rd_req_count: got %0d want 1", req_log.size()); else n_pass++;
    endtask

    task automatic test_cpu_write;
        bit ok;
        req_log.delete();
        ack_delay = 5; stab_err = 0;
        pulse_cpu(1'b0, 1'b1, 23'h008000, 8'hA5);
        wait_idle(vid_valid_cnt, ok);
        ref_arr[23'h008000] = 8'hA5;
        n_checks++; if (!ok) $display("FAIL wr_done: got timeout want done"); else n_pass++;
        n_checks++; if (req_log.size() != 1) $display("FAIL wr_req_count: got %0d want 1", req_log.size()); else n_pass++;
        if (req_log.size() > 0) begin
            n_checks++; if (req_log[0].addr !== 23'h008000) $display("FAIL wr_addr: got %h want 008000", req_log[0].addr); else n_pass++;
            n_checks++; if (req_log[0].we !== 1'b1) $display("FAIL wr_we: got %b want 1", req_log[0].we); else n_pass++;
            n_checks++; if (req_log[0].wdata !== 8'hA5) $display("FAIL wr_wdata: got %h want a5", req_log[0].wdata); else n_pass++;
        end
        n_checks++; if (stab_err != 0) $display("FAIL wr_stable: got %0d changes want 0", stab_err); else n_pass++;
    endtask

    task automatic test_vid_priority;
        bit ok;
        int unsigned v0 = vid_valid_cnt;
        req_log.delete();
        ack_delay = 1;
        @(negedge CLK);
        vid_A = 16'hC000; vid_req = 1'b1; ram_A = 23'h012345; cpu_rd = 1'b1;
        @(negedge CLK);
        vid_req = 1'b0; cpu_rd = 1'b0; vid_A = 16'h0;
        wait_idle(v0 + 1, ok);
        n_checks++; if (!ok) $display("FAIL vp_done: got timeout want done"); else n_pass++;
        n_checks++; if (req_log.size() != 3) $display("FAIL vp_req_count: got %0d want 3", req_log.size()); else n_pass++;
        if (req_log.size() == 3) begin
            n_checks++; if (req_log[0].addr !== 23'h00C000) $display("FAIL vp_addr0: got %h want 00c000", req_log[0].addr); else n_pass++;
            n_checks++; if (req_log[1].addr !== 23'h00C001) $display("FAIL vp_addr1: got %h want 00c001", req_log[1].addr); else n_pass++;
            n_checks++; if (req_log[2].addr !== 23'h012345) $display("FAIL vp_addr2: got %h want 012345", req_log[2].addr); else n_pass++;
        end
        n_checks++; if (last_vid !== {ref_read(23'h00C001), ref_read(23'h00C000)})
            $display("FAIL vp_vid_data: got %h want %h", last_vid, {ref_read(23'h00C001), ref_read(23'h00C000)}); else n_pass++;
        n_checks++; if (vid_valid_cnt != v0 + 1) $display("FAIL vp_valid_count: got %0d want %0d", vid_valid_cnt, v0 + 1); else n_pass++;
        n_checks++; if (cpu_din !== ref_read(23'h012345)) $display("FAIL vp_cpu_din: got %h want %h", cpu_din, ref_read(23'h012345)); else n_pass++;
    endtask

    task automatic test_both_edges;
        bit ok, found = 1'b0;
        int unsigned v0;
        req_log.delete();
        ack_delay = 2;
        pulse_cpu(1'b1, 1'b1, 23'h04ABCD, 8'h3E);
        wait_idle(vid_valid_cnt, ok);
        ref_arr[23'h04ABCD] = 8'h3E;
        n_checks++; if (req_log.size() != 1) $display("FAIL be_req_count: got %0d want 1", req_log.size()); else n_pass++;
        if (req_log.size() > 0) begin
            n_checks++; if (req_log[0].we !== 1'b1) $display("FAIL be_we: got %b want 1", req_log[0].we); else n_pass++;
            n_checks++; if (req_log[0].wdata !== 8'h3E) $display("FAIL be_wdata: got %h want 3e", req_log[0].wdata); else n_pass++;
        end
        req_log.delete();
        v0 = vid_valid_cnt; ack_delay = 4;
        @(negedge CLK);
        vid_A = 16'h2468; vid_req = 1'b1;
        @(negedge CLK);
        vid_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (mem_req && mem_addr == 23'h002469) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) $display("FAIL be_vid_hi_seen: got 0 want 1"); else n_pass++;
        @(negedge CLK);
        vid_A = 16'h1000; vid_req = 1'b1;
        @(negedge CLK);
        vid_req = 1'b0;
        wait_idle(v0 + 1, ok);
        repeat (10) @(posedge CLK);
        #1;
        n_checks++; if (vid_valid_cnt != v0 + 1) $display("FAIL be_valid_count: got %0d want %0d", vid_valid_cnt, v0 + 1); else n_pass++;
        n_checks++; if (req_log.size() != 2) $display("FAIL be_vid_req_count: got %0d want 2", req_log.size()); else n_pass++;
        n_checks++; if (last_vid !== {ref_read(23'h002469), ref_read(23'h002468)})
            $display("FAIL be_vid_data: got %h want %h", last_vid, {ref_read(23'h002469), ref_read(23'h002468)}); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        int unsigned v0 = vid_valid_cnt;
        resp_en = 1'b0; mem_ack = 1'b0;
        pulse_cpu(1'b1, 1'b0, 23'h7F0F0F, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (mem_req) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) $display("FAIL rm_req_seen: got 0 want 1"); else n_pass++;
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rm_req_drop: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (cpu_wait !== 1'b0) $display("FAIL rm_wait: got %b want 0", cpu_wait); else n_pass++;
        n_checks++; if (mem_addr !== 23'h0) $display("FAIL rm_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (cpu_din !== 8'hFF) $display("FAIL rm_cpu_din: got %h want ff", cpu_din); else n_pass++;
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        @(negedge CLK);
        mem_ack = 1'b0;
        @(posedge CLK); #1;
        n_checks++; if (cpu_din !== 8'hFF) $display("FAIL rm_late_ack_din: got %h want ff", cpu_din); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rm_late_ack_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (vid_valid_cnt != v0) $display("FAIL rm_late_ack_vid: got %0d want %0d", vid_valid_cnt, v0); else n_pass++;
    endtask

    task automatic test_timeout;
        bit ok;
        req_log.delete();
        resp_en = 1'b1; ack_delay = 0;
        mem_arr[23'h001111] = 8'h11; ref_arr[23'h001111] = 8'h11;
        pulse_cpu(1'b1, 1'b0, 23'h001111, 8'h00);
        wait_idle(vid_valid_cnt, ok);
        n_checks++; if (cpu_din !== 8'h11) $display("FAIL to_pre_read: got %h want 11", cpu_din); else n_pass++;
        resp_en = 1'b0; mem_ack = 1'b0;
`ifdef AMS_MEM_TIMEOUT_EN
        begin
            int unsigned cnt = 0;
            bit done = 1'b0;
            pulse_cpu(1'b1, 1'b0, 23'h055555, 8'h00);
            for (int i = 0; i < 600; i++) begin
                @(posedge CLK); #1;
                if (mem_req) cnt++;
                if (!cpu_wait) begin
                    done = 1'b1;
                    break;
                end
            end
            n_checks++; if (!done) $display("FAIL to_abort: got no abort want abort"); else n_pass++;
            n_checks++; if (cnt != 255) $display("FAIL to_cycles: got %0d want 255", cnt); else n_pass++;
            n_checks++; if (cpu_din !== 8'hFF) $display("FAIL to_cpu_din: got %h want ff", cpu_din); else n_pass++;
            repeat (20) @(posedge CLK);
            #1;
            n_checks++; if (mem_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", mem_err); else n_pass++;
        end
`else
        pulse_cpu(1'b1, 1'b0, 23'h055555, 8'h00);
        repeat (300) @(posedge CLK);
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL nt_req_held: got %b want 1", mem_req); else n_pass++;
        n_checks++; if (cpu_wait !== 1'b1) $display("FAIL nt_wait_held: got %b want 1", cpu_wait); else n_pass++;
        n_checks++; if (mem_err !== 1'b0) $display("FAIL nt_err: got %b want 0", mem_err); else n_pass++;
`endif
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (mem_err !== 1'b0) $display("FAIL to_err_reset: got %b want 0", mem_err); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL to_req_reset: got %b want 0", mem_req); else n_pass++;
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_random;
        bit ok;
        resp_en = 1'b1; stab_err = 0;
        for (int it = 0; it < 24; it++) begin
            int unsigned kind = $urandom_range(0, 3);
            int unsigned v0 = vid_valid_cnt;
            bit do_vid = (kind >= 2);
            bit do_cpu = (kind != 2);
            bit is_wr = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
            bit rd_too = is_wr ? ($urandom_range(0, 1) == 1) : 1'b1;
            logic [22:0] ca = 23'h050000 | 23'($urandom_range(0, 63));
            logic [7:0]  cd = 8'($urandom);
            logic [15:0] va = 16'h4000 | 16'($urandom_range(0, 31) * 2);
            logic [15:0] exp_vid = {ref_read({7'b0, va | 16'h0001}), ref_read({7'b0, va})};
            logic [7:0]  exp_din = ref_read(ca);
            req_t        exp_q[$];
            req_t        e;
            req_log.delete();
            ack_delay = $urandom_range(0, 4);
            if (do_vid) begin
                e.addr = {7'b0, va}; e.we = 1'b0; e.wdata = '0; exp_q.push_back(e);
                e.addr = {7'b0, va | 16'h0001}; exp_q.push_back(e);
            end
            if (do_cpu) begin
                e.addr = ca; e.we = is_wr; e.wdata = cd; exp_q.push_back(e);
                if (is_wr) ref_arr[ca] = cd;
            end
            @(negedge CLK);
            vid_req = do_vid; vid_A = va;
            cpu_rd = do_cpu && rd_too; cpu_wr = do_cpu && is_wr; ram_A = ca; cpu_dout = cd;
            @(negedge CLK);
            vid_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; ram_A = 23'($urandom); vid_A = 16'($urandom);
            wait_idle(v0 + (do_vid ? 1 : 0), ok);
            n_checks++; if (!ok) $display("FAIL rnd%0d_done: got timeout want done", it); else n_pass++;
            n_checks++; if (req_log.size() != exp_q.size())
                $display("FAIL rnd%0d_req_count: got %0d want %0d", it, req_log.size(), exp_q.size()); else n_pass++;
            for (int k = 0; k < exp_q.size() && k < req_log.size(); k++) begin
                n_checks++; if (req_log[k].addr !== exp_q[k].addr || req_log[k].we !== exp_q[k].we ||
                                (exp_q[k].we && req_log[k].wdata !== exp_q[k].wdata))
                    $display("FAIL rnd%0d_req%0d: got %h/%b/%h want %h/%b/%h", it, k, req_log[k].addr, req_log[k].we,
                             req_log[k].wdata, exp_q[k].addr, exp_q[k].we, exp_q[k].wdata); else n_pass++;
            end
            if (do_cpu && !is_wr) begin
                n_checks++; if (cpu_din !== exp_din) $display("FAIL rnd%0d_cpu_din: got %h want %h", it, cpu_din, exp_din); else n_pass++;
            end
            if (do_vid) begin
                n_checks++; if (last_vid !== exp_vid) $display("FAIL rnd%0d_vid_data: got %h want %h", it, last_vid, exp_vid); else n_pass++;
            end
        end
        n_checks++; if (stab_err != 0) $display("FAIL rnd_stable: got %0d changes want 0", stab_err); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; ram_A = '0; cpu_dout = '0;
        vid_req = 1'b0; vid_A = '0; mem_ack = 1'b0; mem_rdata = '0;
        test_reset;
        test_cpu_read;
        test_cpu_write;
        test_vid_priority;
        test_both_edges;
        test_reset_mid;
        test_timeout;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
